// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Scan sequencer for a shared 4-digit 7-segment display. Four bus-writable
//   digit registers are time-multiplexed onto the sel/seg pins. An all-off
//   blanking gap precedes every digit so the previous pattern cannot ghost
//   onto the next digit.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   wr_en       one-cycle register write strobe
//   wr_addr     0-3 digit reg, 4 ctrl reg {enable[4], decode[3:0]}, 5-7 ignored
//   wr_data     write data
//   sel         digit select, active-low one-hot, 4'hF = none
//   seg         segments {dp,g,f,e,d,c,b,a}, active-low, 8'hFF = off
//   digit_idx   digit currently in its BLANK/SHOW slot
//   frame_tick  one-cycle pulse when the index wraps 3 -> 0
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int SCAN_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [3:0] sel,
   output logic [7:0] seg,
   output logic [1:0] digit_idx,
   output logic       frame_tick
);

   localparam int CNT_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   // register file
   logic [3:0][7:0] r_dig;
   logic [3:0]      r_decode;
   logic            r_enable;

   // scan state
   state_t          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]      r_idx;
   logic [3:0]      r_sel;
   logic [7:0]      r_seg;
   logic            r_tick;

   // next values
   logic [3:0][7:0] w_dig_nxt;
   logic [3:0]      w_decode_nxt;
   logic            w_enable_nxt;
   state_t          w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]      w_idx_nxt;
   logic            w_tick_nxt;
   logic [3:0]      w_sel_nxt;
   logic [7:0]      w_seg_nxt;
   logic [7:0]      w_dig_sel;
   logic [7:0]      w_pattern;

   // Active-high {g,f,e,d,c,b,a} for a hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Register image after this cycle's write. The scan outputs are built from
   // these so a write is visible on the very edge that stores it.
   always_comb begin
      w_dig_nxt    = r_dig;
      w_decode_nxt = r_decode;
      w_enable_nxt = r_enable;
      if (wr_en) begin
         if (wr_addr[2] == 1'b0) begin
            w_dig_nxt[wr_addr[1:0]] = wr_data;
         end else if (wr_addr == 3'd4) begin
            w_decode_nxt = wr_data[3:0];
            w_enable_nxt = wr_data[4];
         end
      end
   end

   // Scan FSM next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_tick_nxt  = 1'b0;
      if (!w_enable_nxt) begin
         // parked exactly in the reset state; re-enable resumes from here
         w_state_nxt = ST_BLANK;
         w_cnt_nxt   = '0;
         w_idx_nxt   = 2'd0;
      end else begin
         case (r_state)
            ST_BLANK: begin
               if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                  w_state_nxt = ST_SHOW;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               if (r_cnt == CNT_W'(SCAN_CYCLES - 1)) begin
                  w_state_nxt = ST_BLANK;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = r_idx + 2'd1;
                  w_tick_nxt  = (r_idx == 2'd3);
               end
            end
         endcase
      end
   end

   // Output pattern for the digit that will be in its slot after this edge
   always_comb begin
      w_dig_sel = w_dig_nxt[w_idx_nxt];
      if (w_decode_nxt[w_idx_nxt]) begin
         w_pattern = {w_dig_sel[7], hex7(w_dig_sel[3:0])};
      end else begin
         w_pattern = w_dig_sel;
      end
      if (w_state_nxt == ST_SHOW) begin
         w_sel_nxt = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt = ~w_pattern;
      end else begin
         w_sel_nxt = 4'hF;
         w_seg_nxt = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dig    <= '0;
         r_decode <= 4'hF;
         r_enable <= 1'b1;
         r_state  <= ST_BLANK;
         r_cnt    <= '0;
         r_idx    <= 2'd0;
         r_sel    <= 4'hF;
         r_seg    <= 8'hFF;
         r_tick   <= 1'b0;
      end else begin
         r_dig    <= w_dig_nxt;
         r_decode <= w_decode_nxt;
         r_enable <= w_enable_nxt;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_sel    <= w_sel_nxt;
         r_seg    <= w_seg_nxt;
         r_tick   <= w_tick_nxt;
      end
   end

   assign sel        = r_sel;
   assign seg        = r_seg;
   assign digit_idx  = r_idx;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with SCAN_CYCLES=8, BLANK_CYCLES=2.
//   The stimulus process pushes one hand-computed expectation per clock
//   period; the monitor pops one entry at every falling edge and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] seg;
      logic [1:0] idx;
      logic       tick;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] sel;
   logic [7:0] seg;
   logic [1:0] digit_idx;
   logic       frame_tick;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_pop    = 0;

   seg_scan_ctrl #(.SCAN_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .sel        (sel),
      .seg        (seg),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // monitor: one expectation per period, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (!(sel inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
         failures++;
         $display("FAIL sel_legal t=%0t sel=%h not in {F,E,D,B,7}", $time, sel);
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({sel, seg, digit_idx, frame_tick} !== e) begin
            failures++;
            $display("FAIL scan[%0d] sel/seg/idx/tick got %h/%h/%0d/%0b want %h/%h/%0d/%0b",
                     n_pop, sel, seg, digit_idx, frame_tick, e.sel, e.seg, e.idx, e.tick);
         end
         n_pop++;
      end
   end

   // one period: queue its expectation, then move to just after the next edge
   task automatic cyc(input logic [3:0] s, input logic [7:0] g,
                      input logic [1:0] i, input logic t);
      exp_t e;
      e.sel = s; e.seg = g; e.idx = i; e.tick = t;
      q.push_back(e);
      @(posedge clk);
      #2;
      wr_en = 1'b0;
   endtask

   // arm a write that is captured at the end of the next cyc()
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic blank(input logic [1:0] i, input logic t);
      cyc(4'hF, 8'hFF, i, t);
      cyc(4'hF, 8'hFF, i, 1'b0);
   endtask

   task automatic show(input logic [3:0] s, input logic [7:0] g,
                       input logic [1:0] i, input int n);
      for (int k = 0; k < n; k++) cyc(s, g, i, 1'b0);
   endtask

   // digit 0 lit through digit 3 lit, with the gaps in between
   task automatic rest(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
      show(4'hE, s0, 2'd0, 8);
      blank(2'd1, 1'b0);
      show(4'hD, s1, 2'd1, 8);
      blank(2'd2, 1'b0);
      show(4'hB, s2, 2'd2, 8);
      blank(2'd3, 1'b0);
      show(4'h7, s3, 2'd3, 8);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 8'h00;
      @(posedge clk);
      #2;
      // reset values
      cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      reset = 1'b1;

      // defaults: every digit decodes 0 -> C0
      blank(2'd0, 1'b0);
      rest(8'hC0, 8'hC0, 8'hC0, 8'hC0);

      // frame wrap tick, decoded A+dp and 8
      wr(3'd1, 8'h8A); cyc(4'hF, 8'hFF, 2'd0, 1'b1);
      wr(3'd2, 8'h08); cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      rest(8'hC0, 8'h08, 8'h80, 8'hC0);

      // decode off: raw patterns
      wr(3'd4, 8'h10); cyc(4'hF, 8'hFF, 2'd0, 1'b1);
      wr(3'd3, 8'h49); cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      rest(8'hFF, 8'h75, 8'hF7, 8'hB6);

      // decode back on; ignored address; write to the lit digit mid-dwell
      wr(3'd4, 8'h1F); cyc(4'hF, 8'hFF, 2'd0, 1'b1);
      wr(3'd5, 8'h00); cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      show(4'hE, 8'hC0, 2'd0, 3);
      wr(3'd0, 8'h01); cyc(4'hE, 8'hC0, 2'd0, 1'b0);
      show(4'hE, 8'hF9, 2'd0, 4);
      blank(2'd1, 1'b0);
      show(4'hD, 8'h08, 2'd1, 8);
      blank(2'd2, 1'b0);
      show(4'hB, 8'h80, 2'd2, 8);
      blank(2'd3, 1'b0);
      show(4'h7, 8'h90, 2'd3, 8);

      // disable mid-show of digit 2, hold past where a wrap would occur
      blank(2'd0, 1'b1);
      show(4'hE, 8'hF9, 2'd0, 8);
      blank(2'd1, 1'b0);
      show(4'hD, 8'h08, 2'd1, 8);
      blank(2'd2, 1'b0);
      show(4'hB, 8'h80, 2'd2, 2);
      wr(3'd4, 8'h00); cyc(4'hB, 8'h80, 2'd2, 1'b0);
      for (int k = 0; k < 12; k++) cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      wr(3'd0, 8'h06); cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      for (int k = 0; k < 30; k++) cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      // re-enable: schedule restarts as from reset
      wr(3'd4, 8'h1F); cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      show(4'hE, 8'h82, 2'd0, 8);
      blank(2'd1, 1'b0);
      show(4'hD, 8'h08, 2'd1, 3);

      // asynchronous reset mid-dwell, then the power-on sequence again
      reset = 1'b0;
      cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      cyc(4'hF, 8'hFF, 2'd0, 1'b0);
      reset = 1'b1;
      blank(2'd0, 1'b0);
      rest(8'hC0, 8'hC0, 8'hC0, 8'hC0);
      blank(2'd0, 1'b1);

      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
